// File: rtl/exhaustive_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : exhaustive_vector_sequencer
// Sweeps all 2**N_WIDTH input patterns into a DUT, samples each response
// after a settle delay, emits {vector, response} records and folds them into a MISR.
// Rev     : 1.0
// ============================================================================
module exhaustive_vector_sequencer #(
    parameter int                   N_WIDTH       = 6,
    parameter int                   OUT_WIDTH     = 1,
    parameter int                   SETTLE_CYCLES = 1,
    parameter int                   SIG_WIDTH     = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY      = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SIG_SEED      = 16'h0000
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_WIDTH-1:0]   vec_out,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_vec,
    output logic [OUT_WIDTH-1:0] rec_resp,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [N_WIDTH:0]     vec_count,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_EMIT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [7:0]         C_SETTLE   = 8'(SETTLE_CYCLES);
    localparam logic [N_WIDTH-1:0] C_VEC_ONE  = {{(N_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [N_WIDTH:0]   C_CNT_ONE  = {{N_WIDTH{1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [N_WIDTH-1:0]   vec_q, vec_d;
    logic [7:0]           settle_q, settle_d;
    logic [N_WIDTH-1:0]   rec_vec_q, rec_vec_d;
    logic [OUT_WIDTH-1:0] rec_resp_q, rec_resp_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [N_WIDTH:0]     count_q, count_d;

    logic                 w_load;
    logic                 w_accept;
    logic [SIG_WIDTH-1:0] w_resp_ext;
    logic [SIG_WIDTH-1:0] w_sig_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_APPLY;
                S_APPLY:        state_d = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
                S_SETTLE:       if (settle_q <= 8'd1) state_d = S_CAPTURE;
                S_CAPTURE:      state_d = S_EMIT;
                S_EMIT: begin
                    if (rec_ready) state_d = (&vec_q) ? S_DONE : S_APPLY;
                end
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rec_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_APPLY, S_SETTLE, S_CAPTURE: busy = 1'b1;
            S_EMIT: begin
                busy      = 1'b1;
                rec_valid = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    assign w_load   = !abort && start && (state_q == S_IDLE || state_q == S_DONE);
    assign w_accept = !abort && (state_q == S_EMIT) && rec_ready;

    always_comb begin
        w_resp_ext                = '0;
        w_resp_ext[OUT_WIDTH-1:0] = dut_out;
    end

    assign w_sig_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                      ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : '0)
                      ^ w_resp_ext;

    always_comb begin
        vec_d      = vec_q;
        settle_d   = settle_q;
        rec_vec_d  = rec_vec_q;
        rec_resp_d = rec_resp_q;
        sig_d      = sig_q;
        count_d    = count_q;
        if (w_load) begin
            vec_d   = '0;
            count_d = '0;
            sig_d   = SIG_SEED;
        end else if (!abort) begin
            case (state_q)
                S_APPLY:  settle_d = C_SETTLE;
                S_SETTLE: settle_d = settle_q - 8'd1;
                S_CAPTURE: begin
                    rec_vec_d  = vec_q;
                    rec_resp_d = dut_out;
                    sig_d      = w_sig_next;
                end
                S_EMIT: begin
                    if (w_accept) begin
                        count_d = count_q + C_CNT_ONE;
                        // The all-ones vector is final: hold it rather than wrap
                        if (!(&vec_q)) vec_d = vec_q + C_VEC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            vec_q      <= '0;
            settle_q   <= '0;
            rec_vec_q  <= '0;
            rec_resp_q <= '0;
            sig_q      <= SIG_SEED;
            count_q    <= '0;
        end else begin
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            rec_vec_q  <= rec_vec_d;
            rec_resp_q <= rec_resp_d;
            sig_q      <= sig_d;
            count_q    <= count_d;
        end
    end

    assign vec_out   = vec_q;
    assign rec_vec   = rec_vec_q;
    assign rec_resp  = rec_resp_q;
    assign signature = sig_q;
    assign vec_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_exhaustive_vector_sequencer
// Directed bench for exhaustive_vector_sequencer with three parameter sets.
// Rev     : 1.0
// ============================================================================
module tb_exhaustive_vector_sequencer;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   mode  = 0;

    // Instance A: default parameters
    logic        start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b1;
    logic [5:0]  vec_a, rvec_a;
    logic        dut_a, rv_a, rresp_a, busy_a, done_a;
    logic [15:0] sig_a;
    logic [6:0]  cnt_a;
    assign dut_a = (mode == 0) ? (vec_a[0] ^ vec_a[5]) : (mode == 2);

    exhaustive_vector_sequencer u_a (
        .CK(CK), .reset(reset), .start(start_a), .abort(abort_a),
        .vec_out(vec_a), .dut_out(dut_a), .rec_valid(rv_a), .rec_ready(rdy_a),
        .rec_vec(rvec_a), .rec_resp(rresp_a), .signature(sig_a),
        .vec_count(cnt_a), .busy(busy_a), .done(done_a)
    );

    // Instances B (no settle) and C (settle 5, non-zero seed)
    logic        start_bc = 1'b0, abort_bc = 1'b0, rdy_bc = 1'b1;
    logic [5:0]  vec_b, rvec_b, vec_c, rvec_c;
    logic        rv_b, rresp_b, busy_b, done_b, rv_c, rresp_c, busy_c, done_c;
    logic [15:0] sig_b, sig_c;
    logic [6:0]  cnt_b, cnt_c;

    exhaustive_vector_sequencer #(.SETTLE_CYCLES(0)) u_b (
        .CK(CK), .reset(reset), .start(start_bc), .abort(abort_bc),
        .vec_out(vec_b), .dut_out(vec_b[0]), .rec_valid(rv_b), .rec_ready(rdy_bc),
        .rec_vec(rvec_b), .rec_resp(rresp_b), .signature(sig_b),
        .vec_count(cnt_b), .busy(busy_b), .done(done_b)
    );

    exhaustive_vector_sequencer #(.SETTLE_CYCLES(5), .SIG_SEED(16'hBEEF)) u_c (
        .CK(CK), .reset(reset), .start(start_bc), .abort(abort_bc),
        .vec_out(vec_c), .dut_out(vec_c[0]), .rec_valid(rv_c), .rec_ready(rdy_bc),
        .rec_vec(rvec_c), .rec_resp(rresp_c), .signature(sig_c),
        .vec_count(cnt_c), .busy(busy_c), .done(done_c)
    );

    function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, r};
    endfunction

    function automatic logic resp_of(input int md, input logic [5:0] v);
        return (md == 0) ? (v[0] ^ v[5]) : (md == 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    // Wait (bounded) until instance A presents the record for vector v
    task automatic wait_rec(input logic [5:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (rv_a && rvec_a == v) ok = 1'b1;
        end
    endtask

    // Full sweep on A with rec_ready held high, checking every record
    task automatic sweep_a(input string tag, output logic [15:0] model);
        int          cycles;
        logic [5:0]  idx;
        int          nrec;
        model  = 16'h0000;
        idx    = '0;
        nrec   = 0;
        cycles = 0;
        pulse_start_a();
        while (!done_a && cycles < 400) begin
            step();
            cycles++;
            if (rv_a) begin
                check({tag, "_rec_vec"}, {26'd0, rvec_a}, {26'd0, idx});
                check({tag, "_rec_resp"}, {31'd0, rresp_a}, {31'd0, resp_of(mode, idx)});
                model = misr(model, resp_of(mode, idx));
                idx   = idx + 6'd1;
                nrec++;
            end
        end
        check({tag, "_cycles"}, cycles, 256);
        check({tag, "_records"}, nrec, 64);
        check({tag, "_count"}, {25'd0, cnt_a}, 32'd64);
        check({tag, "_sig"}, {16'd0, sig_a}, {16'd0, model});
        check({tag, "_vec_hold"}, {26'd0, vec_a}, 32'd63);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        bit          ok;
        logic [15:0] model, mb, mc;
        int          cycles, db, dc;

        // Reset state
        step();
        step();
        check("rst_valid", {31'd0, rv_a}, 0);
        check("rst_vec", {26'd0, vec_a}, 0);
        check("rst_sig", {16'd0, sig_a}, 0);
        check("rst_count", {25'd0, cnt_a}, 0);
        check("rst_busy_done", {30'd0, busy_a, done_a}, 0);
        check("rst_sig_seed_c", {16'd0, sig_c}, 32'hBEEF);
        #2 reset = 1'b0;
        step();
        check("idle_busy", {31'd0, busy_a}, 0);

        // Full sweep, dut_out = vec[0]^vec[5]
        mode = 0;
        sweep_a("sweep_xor", model);
        check("sweep_xor_done", {31'd0, done_a}, 1);

        // Back-pressure at vector 10, then abort at vector 20
        pulse_start_a();
        check("restart_vec0", {26'd0, vec_a}, 0);
        check("restart_busy", {30'd0, busy_a, done_a}, 32'h2);
        wait_rec(6'd10, ok);
        check("bp_reach10", {31'd0, ok}, 1);
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'd0, rv_a}, 1);
            check("bp_hold_vec", {26'd0, rvec_a}, 10);
            check("bp_hold_resp", {31'd0, rresp_a}, 0);
        end
        rdy_a = 1'b1;
        step();
        check("bp_after_valid", {31'd0, rv_a}, 0);
        check("bp_after_count", {25'd0, cnt_a}, 11);
        wait_rec(6'd11, ok);
        check("bp_next11", {31'd0, ok}, 1);
        check("bp_resp11", {31'd0, rresp_a}, 1);

        wait_rec(6'd20, ok);
        check("ab_reach20", {31'd0, ok}, 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        model = 16'h0000;
        for (int v = 0; v <= 20; v++) model = misr(model, resp_of(0, 6'(v)));
        check("ab_valid", {31'd0, rv_a}, 0);
        check("ab_busy_done", {30'd0, busy_a, done_a}, 0);
        check("ab_count", {25'd0, cnt_a}, 20);
        check("ab_sig", {16'd0, sig_a}, {16'd0, model});
        step();
        check("ab_idle_stays", {30'd0, busy_a, rv_a}, 0);
        check("ab_sig_hold", {16'd0, sig_a}, {16'd0, model});
        pulse_start_a();
        check("ab_restart_vec", {26'd0, vec_a}, 0);
        check("ab_restart_count", {25'd0, cnt_a}, 0);
        check("ab_restart_busy", {31'd0, busy_a}, 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;

        // Constant responses
        mode = 1;
        sweep_a("sweep_zero", model);
        check("sweep_zero_sig0", {16'd0, sig_a}, 0);
        mode = 2;
        sweep_a("sweep_ones", model);

        // Asynchronous reset while a record is pending
        pulse_start_a();
        wait_rec(6'd3, ok);
        check("ar_reach3", {31'd0, ok}, 1);
        check("ar_sig_pre", {16'd0, sig_a}, 32'h000F);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", {31'd0, rv_a}, 0);
        check("ar_vec", {26'd0, vec_a}, 0);
        check("ar_sig", {16'd0, sig_a}, 0);
        check("ar_busy", {31'd0, busy_a}, 0);
        #3 reset = 1'b0;
        step();
        check("ar_idle", {30'd0, busy_a, done_a}, 0);

        // Settle 0 and settle 5 timing, start while busy ignored
        mb = 16'h0000;
        mc = 16'hBEEF;
        for (int v = 0; v < 64; v++) begin
            mb = misr(mb, 1'(v & 1));
            mc = misr(mc, 1'(v & 1));
        end
        start_bc = 1'b1;
        step();
        start_bc = 1'b0;
        cycles = 0;
        db = -1;
        dc = -1;
        while (cycles < 700 && (db < 0 || dc < 0)) begin
            step();
            cycles++;
            start_bc = (cycles == 100);
            if (done_b && db < 0) db = cycles;
            if (done_c && dc < 0) dc = cycles;
        end
        start_bc = 1'b0;
        check("s0_cycles", db, 192);
        check("s5_cycles", dc, 512);
        check("s0_count", {25'd0, cnt_b}, 64);
        check("s5_count", {25'd0, cnt_c}, 64);
        check("s0_sig", {16'd0, sig_b}, {16'd0, mb});
        check("s5_sig_seeded", {16'd0, sig_c}, {16'd0, mc});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
